elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
Single-car call scheduler that sits between the button inputs and the car motion/door datapath. It latches hall calls (up/down) and cab calls for 8 floors and selects travel direction using LOOK (sweep until no calls ahead, then reverse). It sequences the car one floor at a time over a req/done handshake and times the door dwell. It drives the call lamps and the direction indicator.

Parameters:
NFLOORS, 8, number of floors; floor index 0..NFLOORS-1.
FW, 3, width of the binary floor index.
DWELL_TICKS, 24, door-open dwell length in tick pulses.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick  in  1  one-cycle slow timebase pulse used for the dwell count
hall_up  in  NFLOORS  hall up buttons (level); bit NFLOORS-1 ignored
hall_dn  in  NFLOORS  hall down buttons (level); bit 0 ignored
cab  in  NFLOORS  in-car floor buttons (level)
door_open_btn  in  1  extend dwell
door_close_btn  in  1  end dwell early
cur_floor  in  FW  car position (binary), valid while car is stopped
step_done  in  1  one-cycle pulse: car finished a one-floor step; cur_floor updated in the same cycle
move_req  out  1  request a one-floor step
direct  out  1  travel direction: 0 = up, 1 = down
door_open  out  1  door command, 1 = open
up_lamp  out  NFLOORS  pending hall-up calls
dn_lamp  out  NFLOORS  pending hall-down calls
cab_lamp  out  NFLOORS  pending cab calls
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (async): state=IDLE. Outputs go to: move_req=0, direct=0, door_open=0, all lamps=0, busy=0. Dwell counter=0. Reset mid-MOVE drops move_req immediately.
- Call latching: every cycle, a pressed button sets its pending bit. Exception: a press at cur_floor while in DOOR is absorbed. It does not set the bit, and it restarts the dwell count at 0. Lamps equal the pending registers directly.
- Derived terms, evaluated at cur_floor f:
  - ahead: any pending bit strictly above f when direct=0, or strictly below f when direct=1.
  - behind: the same test in the opposite direction.
  - here: cab[f] or up[f] or dn[f].
- IDLE:
  - pending at f only: go to DOOR and clear here.
  - pending elsewhere: go to DECIDE.
- DECIDE (1 cycle):
  - if ahead: go to MOVE.
  - else if behind: toggle direct, then go to MOVE.
  - else if here: go to DOOR.
  - else: go to IDLE.
- MOVE:
  - move_req=1 and direct held stable until step_done.
  - On step_done: move_req=0 in the next cycle, then go to CHECK.
  - direct never changes while move_req=1.
- CHECK (1 cycle): stop at f if any of:
  - cab[f]
  - hall bit in the travel direction at f
  - opposite hall bit at f and !ahead
  - f = 0 or f = NFLOORS-1 (end of shaft)
  If stopping: go to DOOR. Otherwise: go to MOVE with move_req=1 again.
- Clearing on stop (entering DOOR), for departure direction d:
  - d = direct if ahead, otherwise the opposite of direct.
  - Always clear cab[f].
  - Clear the hall bit at f matching d. If no other pending call exists anywhere, clear both hall bits at f.
  - If d differs from direct, direct takes d on DOOR entry.
- DOOR:
  - door_open=1; the counter increments on tick.
  - Counter reaching DWELL_TICKS, or door_close_btn=1: door_open=0 next cycle. Then go to DECIDE if any bit is pending, else IDLE.
  - door_open_btn=1 clears the counter, and takes priority over door_close_btn in the same cycle.
- Simultaneous events: a press and a clear of the same bit in the same cycle resolve to clear, only for floor f on DOOR entry. Presses at other floors always set.
- Invalid bits hall_up[NFLOORS-1] and hall_dn[0] never latch; their lamps stay 0.
- Width rules: cur_floor values >= NFLOORS are treated as NFLOORS-1. The dwell counter saturates and does not wrap.
- Latency:
  - Press at another floor in IDLE to move_req=1: 2 cycles (latch, DECIDE).
  - step_done to door_open=1: 2 cycles (CHECK, DOOR).

Test Plan:
- Reset, cur_floor=0, pulse cab[5] → cab_lamp=8'h20; move_req=1 with direct=0 two cycles later. After 5 step_done pulses (cur_floor 1..5): door_open=1, cab_lamp=0. After 24 ticks: door_open=0, busy=0.
- Car at 2 moving up, with hall_dn[4] and cab[6] pending → passes 4, stops at 6. Then direct=1, stops at 4, and dn_lamp clears only on that stop.
- Car at 3 idle, press hall_up[3] → DOOR with no move_req; up_lamp stays 0. A second press during dwell restarts the count (dwell measured as 24 ticks after the last press).
- In DOOR, assert door_close_btn at tick 5 → door_open=0 next cycle. Assert door_open_btn together with door_close_btn → door stays open and the counter resets.
- Assert rst while move_req=1 with calls pending → move_req, lamps, door_open and direct all 0 in the same cycle. After release, the scheduler sits in IDLE with busy=0.
- Press hall_up[7] and hall_dn[0] → no lamp and no movement. Car at 7 going up with cab[1] pending → direct flips to 1 in DECIDE and move_req asserts.

Source files
------------

// File: rtl/elevator_call_scheduler_if.sv
// Button, position, motion-handshake and indicator signals of the call scheduler.
// Pure wiring; adds no latency.
// The car acknowledges move_req with a one-cycle step_done; nothing else backpressures.
interface elevator_call_scheduler_if #(
    parameter int NFLOORS = 8,
    parameter int FW      = 3
);
    // slow timebase and operator inputs
    logic               tick;
    logic [NFLOORS-1:0] hall_up;
    logic [NFLOORS-1:0] hall_dn;
    logic [NFLOORS-1:0] cab;
    logic               door_open_btn;
    logic               door_close_btn;

    // car position and step handshake
    logic [FW-1:0]      cur_floor;
    logic               step_done;
    logic               move_req;
    logic               direct;

    // door command and indicators
    logic               door_open;
    logic [NFLOORS-1:0] up_lamp;
    logic [NFLOORS-1:0] dn_lamp;
    logic [NFLOORS-1:0] cab_lamp;
    logic               busy;

    // environment side: buttons and car datapath
    modport master (
        output tick, hall_up, hall_dn, cab, door_open_btn, door_close_btn,
        output cur_floor, step_done,
        input  move_req, direct, door_open, up_lamp, dn_lamp, cab_lamp, busy
    );

    // scheduler side
    modport slave (
        input  tick, hall_up, hall_dn, cab, door_open_btn, door_close_btn,
        input  cur_floor, step_done,
        output move_req, direct, door_open, up_lamp, dn_lamp, cab_lamp, busy
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Single-car LOOK call scheduler: latches hall/cab calls, sequences one-floor steps, times door dwell.
// Press elsewhere in IDLE -> move_req after 2 cycles; step_done -> door_open after 2 cycles.
// move_req holds (direction frozen) until the car returns step_done; dwell may be extended/cut by buttons.
module elevator_call_scheduler #(
    parameter int NFLOORS     = 8,
    parameter int FW          = 3,
    parameter int DWELL_TICKS = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    elevator_call_scheduler_if.slave  bus
);

    localparam int CW = $clog2(DWELL_TICKS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECIDE = 3'd1;
    localparam logic [2:0] S_MOVE   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DOOR   = 3'd4;

    // top floor has no up button, bottom floor has no down button
    localparam logic [NFLOORS-1:0] VALID_UP = {1'b0, {(NFLOORS-1){1'b1}}};
    localparam logic [NFLOORS-1:0] VALID_DN = {{(NFLOORS-1){1'b1}}, 1'b0};

    logic [2:0]         state, state_n;
    logic [NFLOORS-1:0] up_q, dn_q, cab_q;
    logic               dir_q;
    logic [CW-1:0]      cnt_q;

    logic [FW-1:0]      f;
    logic [NFLOORS-1:0] fhot, above, below;
    logic [NFLOORS-1:0] up_in, dn_in, cab_in, keep;
    logic [NFLOORS-1:0] up_m, dn_m, cab_m, all_m;
    logic [NFLOORS-1:0] clr_up, clr_dn, clr_cab;
    logic               absorb, any_above, any_below, ahead, behind, here, other, any_pend;
    logic               dep, hall_same, hall_opp, at_end, stop_here;
    logic               dwell_done, hold;
    logic               enter_door, dir_toggle;

    // out-of-range positions are read as the top floor
    assign f = (int'(bus.cur_floor) >= NFLOORS) ? FW'(NFLOORS - 1) : bus.cur_floor;

    // floor-relative masks: the current floor, and every floor above/below it
    always_comb begin
        fhot  = '0;
        above = '0;
        below = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            fhot[i]  = (i == int'(f));
            above[i] = (i >  int'(f));
            below[i] = (i <  int'(f));
        end
    end

    // Merge this cycle's presses with the pending registers so every decision
    // sees a press in the cycle it arrives. At the open door a press at the
    // car's own floor is served by the open door instead of being latched.
    assign up_in  = bus.hall_up & VALID_UP;
    assign dn_in  = bus.hall_dn & VALID_DN;
    assign cab_in = bus.cab;
    assign absorb = (state == S_DOOR) && (|((up_in | dn_in | cab_in) & fhot));
    assign keep   = absorb ? ~fhot : '1;

    assign up_m  = up_q  | (up_in  & keep);
    assign dn_m  = dn_q  | (dn_in  & keep);
    assign cab_m = cab_q | (cab_in & keep);
    assign all_m = up_m | dn_m | cab_m;

    // LOOK terms relative to the current travel direction
    assign any_above = |(all_m & above);
    assign any_below = |(all_m & below);
    assign ahead     = dir_q ? any_below : any_above;
    assign behind    = dir_q ? any_above : any_below;
    assign here      = |(all_m & fhot);
    assign other     = |(all_m & ~fhot);
    assign any_pend  = |all_m;

    // direction the car will leave in after a stop here
    assign dep = ahead ? dir_q : ~dir_q;

    // Calls served by a stop: the cab call, the hall call matching the
    // departure direction, and both hall calls when nothing else is waiting.
    assign clr_cab = fhot;
    assign clr_up  = (!dep || !other) ? fhot : '0;
    assign clr_dn  = ( dep || !other) ? fhot : '0;

    // stop test used after each completed step
    assign hall_same = dir_q ? |(dn_m & fhot) : |(up_m & fhot);
    assign hall_opp  = dir_q ? |(up_m & fhot) : |(dn_m & fhot);
    assign at_end    = (f == '0) || (int'(f) == NFLOORS - 1);
    assign stop_here = (|(cab_m & fhot)) || hall_same || (hall_opp && !ahead) || at_end;

    // door-open button (or a press at this floor) beats both timeout and close button
    assign dwell_done = (cnt_q == CW'(DWELL_TICKS)) || bus.door_close_btn;
    assign hold       = bus.door_open_btn || absorb;

    // next-state selection; every path into DOOR goes through enter_door
    always_comb begin
        state_n    = state;
        enter_door = 1'b0;
        dir_toggle = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_pend) begin
                    if (here && !other) enter_door = 1'b1;
                    else                state_n    = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (ahead) begin
                    state_n = S_MOVE;
                end else if (behind) begin
                    state_n    = S_MOVE;
                    dir_toggle = 1'b1;
                end else if (here) begin
                    enter_door = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_MOVE: begin
                if (bus.step_done) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (stop_here) enter_door = 1'b1;
                else           state_n    = S_MOVE;
            end
            S_DOOR: begin
                if (!hold && dwell_done) state_n = any_pend ? S_DECIDE : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (enter_door) state_n = S_DOOR;
    end

    // state, pending calls and travel direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            up_q  <= '0;
            dn_q  <= '0;
            cab_q <= '0;
            dir_q <= 1'b0;
        end else begin
            state <= state_n;
            if (enter_door) begin
                // a clear at the stop floor wins over a simultaneous press there
                up_q  <= up_m  & ~clr_up;
                dn_q  <= dn_m  & ~clr_dn;
                cab_q <= cab_m & ~clr_cab;
                dir_q <= dep;
            end else begin
                up_q  <= up_m;
                dn_q  <= dn_m;
                cab_q <= cab_m;
                if (dir_toggle) dir_q <= ~dir_q;
            end
        end
    end

    // dwell counter: counts ticks while the door is open, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state != S_DOOR) begin
            cnt_q <= '0;
        end else if (hold) begin
            cnt_q <= '0;
        end else if (bus.tick && (cnt_q < CW'(DWELL_TICKS))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // outputs decode straight from state so reset clears them immediately
    assign bus.move_req  = (state == S_MOVE);
    assign bus.door_open = (state == S_DOOR);
    assign bus.busy      = (state != S_IDLE);
    assign bus.direct    = dir_q;
    assign bus.up_lamp   = up_q;
    assign bus.dn_lamp   = dn_q;
    assign bus.cab_lamp  = cab_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench: directed scenarios plus random button traffic against a floor-list model.
// Outputs checked 1 time unit after each rising edge.
// Car model answers move_req with step_done after 1-3 cycles.
module tb_elevator_call_scheduler;
    localparam int NF    = 8;
    localparam int FW    = 3;
    localparam int DWELL = 24;

    localparam int P_IDLE   = 0;
    localparam int P_DECIDE = 1;
    localparam int P_MOVE   = 2;
    localparam int P_CHECK  = 3;
    localparam int P_DOOR   = 4;

    logic clk;
    logic rst;

    elevator_call_scheduler_if #(.NFLOORS(NF), .FW(FW)) bus ();

    elevator_call_scheduler #(.NFLOORS(NF), .FW(FW), .DWELL_TICKS(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: call lists per floor, phase, direction, dwell count
    bit m_up[NF];
    bit m_dn[NF];
    bit m_cab[NF];
    int m_phase;
    bit m_dir;
    int m_cnt;
    int step_wait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NF-1:0] pack(input bit v[NF]);
        logic [NF-1:0] r;
        for (int i = 0; i < NF; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            m_up[i]  = 0;
            m_dn[i]  = 0;
            m_cab[i] = 0;
        end
        m_phase = P_IDLE;
        m_dir   = 0;
        m_cnt   = 0;
    endtask

    // advance the model by one clock using the inputs currently driven
    task automatic model_step();
        int f;
        bit pu[NF];
        bit pd[NF];
        bit pc[NF];
        bit absorb, ahead, behind, here, other, dep, to_door, same_h, opp_h;
        int n_above, n_below, nxt;
        f = (int'(bus.cur_floor) >= NF) ? NF - 1 : int'(bus.cur_floor);
        absorb = 0;
        if (m_phase == P_DOOR)
            absorb = bus.cab[f] || (f != NF - 1 && bus.hall_up[f]) || (f != 0 && bus.hall_dn[f]);
        for (int i = 0; i < NF; i++) begin
            pu[i] = m_up[i]  || (bus.hall_up[i] && i != NF - 1 && !(absorb && i == f));
            pd[i] = m_dn[i]  || (bus.hall_dn[i] && i != 0      && !(absorb && i == f));
            pc[i] = m_cab[i] || (bus.cab[i] && !(absorb && i == f));
        end
        n_above = 0;
        n_below = 0;
        for (int i = 0; i < NF; i++) begin
            if (pu[i] || pd[i] || pc[i]) begin
                if (i > f) n_above++;
                if (i < f) n_below++;
            end
        end
        ahead  = m_dir ? (n_below > 0) : (n_above > 0);
        behind = m_dir ? (n_above > 0) : (n_below > 0);
        here   = pu[f] || pd[f] || pc[f];
        other  = (n_above + n_below) > 0;
        dep    = ahead ? m_dir : !m_dir;
        nxt     = m_phase;
        to_door = 0;
        case (m_phase)
            P_IDLE: if (here || other) begin
                if (!other) to_door = 1;
                else        nxt = P_DECIDE;
            end
            P_DECIDE: begin
                if (ahead) nxt = P_MOVE;
                else if (behind) begin nxt = P_MOVE; m_dir = !m_dir; end
                else if (here) to_door = 1;
                else nxt = P_IDLE;
            end
            P_MOVE: if (bus.step_done) nxt = P_CHECK;
            P_CHECK: begin
                same_h = m_dir ? pd[f] : pu[f];
                opp_h  = m_dir ? pu[f] : pd[f];
                if (pc[f] || same_h || (opp_h && !ahead) || f == 0 || f == NF - 1) to_door = 1;
                else nxt = P_MOVE;
            end
            default: begin
                if (!(bus.door_open_btn || absorb) && (m_cnt >= DWELL || bus.door_close_btn))
                    nxt = (here || other) ? P_DECIDE : P_IDLE;
            end
        endcase
        if (m_phase == P_DOOR) begin
            if (bus.door_open_btn || absorb) m_cnt = 0;
            else if (bus.tick && m_cnt < DWELL) m_cnt++;
        end else begin
            m_cnt = 0;
        end
        if (to_door) begin
            nxt   = P_DOOR;
            pc[f] = 0;
            if (!other) begin pu[f] = 0; pd[f] = 0; end
            else if (dep) pd[f] = 0;
            else pu[f] = 0;
            m_dir = dep;
        end
        m_phase = nxt;
        for (int i = 0; i < NF; i++) begin
            m_up[i]  = pu[i];
            m_dn[i]  = pd[i];
            m_cab[i] = pc[i];
        end
    endtask

    // one clock: car model, reference model, edge, then compare everything
    task automatic cycle();
        bus.step_done = 1'b0;
        if (m_phase == P_MOVE) begin
            if (step_wait <= 1) begin
                bus.step_done = 1'b1;
                if (m_dir && bus.cur_floor != '0)
                    bus.cur_floor = bus.cur_floor - 1'b1;
                else if (!m_dir && int'(bus.cur_floor) != NF - 1)
                    bus.cur_floor = bus.cur_floor + 1'b1;
                step_wait = $urandom_range(1, 3);
            end else begin
                step_wait--;
            end
        end
        model_step();
        @(posedge clk);
        #1;
        check("ctrl", 32'({bus.move_req, bus.direct, bus.door_open, bus.busy}),
              32'({m_phase == P_MOVE, m_dir, m_phase == P_DOOR, m_phase != P_IDLE}));
        check("lamps", 32'({bus.up_lamp, bus.dn_lamp, bus.cab_lamp}),
              32'({pack(m_up), pack(m_dn), pack(m_cab)}));
    endtask

    task automatic wait_door(input string tag, input bit level, input int max);
        int n = 0;
        while (bus.door_open !== level && n < max) begin
            cycle();
            n++;
        end
        check(tag, 32'(bus.door_open), 32'(level));
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (bus.busy !== 1'b0 && n < max) begin
            cycle();
            n++;
        end
        check(tag, 32'(bus.busy), 32'(0));
    endtask

    task automatic clear_buttons();
        bus.hall_up        = '0;
        bus.hall_dn        = '0;
        bus.cab            = '0;
        bus.door_open_btn  = 1'b0;
        bus.door_close_btn = 1'b0;
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.tick      = 1'b0;
        bus.cur_floor = '0;
        bus.step_done = 1'b0;
        clear_buttons();
        model_reset();
        step_wait = 2;
        #1;
        check("rst_ctrl",  32'({bus.move_req, bus.direct, bus.door_open, bus.busy}), 32'(0));
        check("rst_lamps", 32'({bus.up_lamp, bus.dn_lamp, bus.cab_lamp}), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // trip from 0 to cab call 5, then full dwell
        bus.cab = 8'h20;
        cycle();
        bus.cab = '0;
        check("s1_lamp", 32'(bus.cab_lamp), 32'h20);
        cycle();
        check("s1_mreq", 32'({bus.move_req, bus.direct}), 32'b10);
        wait_door("s1_open", 1'b1, 100);
        check("s1_floor", 32'(bus.cur_floor), 32'd5);
        check("s1_cablamp", 32'(bus.cab_lamp), 32'(0));
        bus.tick = 1'b1;
        n = 0;
        while (bus.door_open && n < 60) begin cycle(); n++; end
        check("s1_dwell", 32'(n), 32'd25);
        check("s1_busy", 32'(bus.busy), 32'(0));
        bus.tick = 1'b0;

        // hall call at the idle car's floor; second press restarts dwell
        bus.cur_floor = 3'd3;
        bus.hall_up   = 8'h08;
        cycle();
        bus.hall_up = '0;
        check("s3_open", 32'({bus.door_open, bus.move_req}), 32'b10);
        check("s3_uplamp", 32'(bus.up_lamp), 32'(0));
        bus.tick = 1'b1;
        repeat (10) cycle();
        bus.hall_up = 8'h08;
        cycle();
        bus.hall_up = '0;
        check("s3_absorb", 32'(bus.up_lamp), 32'(0));
        n = 0;
        while (bus.door_open && n < 60) begin cycle(); n++; end
        check("s3_restart", 32'(n), 32'd25);

        // open button beats close button; close alone ends dwell
        bus.cab = 8'h08;
        cycle();
        bus.cab = '0;
        check("s4_open", 32'(bus.door_open), 32'd1);
        repeat (5) cycle();
        bus.tick           = 1'b0;
        bus.door_open_btn  = 1'b1;
        bus.door_close_btn = 1'b1;
        cycle();
        bus.door_open_btn = 1'b0;
        check("s4_open_wins", 32'(bus.door_open), 32'd1);
        cycle();
        bus.door_close_btn = 1'b0;
        check("s4_close", 32'(bus.door_open), 32'd0);

        // going up from 2: pass hall-down 4, stop at 6, return to 4
        bus.cur_floor = 3'd2;
        bus.cab       = 8'h40;
        bus.hall_dn   = 8'h10;
        cycle();
        clear_buttons();
        bus.tick = 1'b1;
        wait_door("s2_open6", 1'b1, 100);
        check("s2_floor6", 32'(bus.cur_floor), 32'd6);
        check("s2_dn_kept", 32'({bus.dn_lamp, bus.direct}), 32'({8'h10, 1'b1}));
        wait_door("s2_close6", 1'b0, 100);
        wait_door("s2_open4", 1'b1, 100);
        check("s2_floor4", 32'(bus.cur_floor), 32'd4);
        check("s2_dn_clr", 32'(bus.dn_lamp), 32'(0));
        wait_idle("s2_idle", 100);
        bus.tick = 1'b0;

        // reset while moving with calls pending
        bus.cab     = 8'h02;
        bus.hall_dn = 8'h04;
        cycle();
        clear_buttons();
        cycle();
        check("s5_moving", 32'({bus.move_req, bus.direct}), 32'b11);
        #2;
        rst = 1'b1;
        #1;
        check("s5_rst_ctrl",  32'({bus.move_req, bus.direct, bus.door_open, bus.busy}), 32'(0));
        check("s5_rst_lamps", 32'({bus.up_lamp, bus.dn_lamp, bus.cab_lamp}), 32'(0));
        model_reset();
        bus.step_done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check("s5_idle", 32'(bus.busy), 32'(0));

        // nonexistent hall buttons never latch
        bus.hall_up = 8'h80;
        bus.hall_dn = 8'h01;
        cycle();
        clear_buttons();
        check("s7_lamps", 32'({bus.up_lamp, bus.dn_lamp}), 32'(0));
        cycle();
        check("s7_still", 32'({bus.busy, bus.move_req}), 32'(0));

        // at top floor heading up, call below flips direction
        bus.cur_floor = 3'd7;
        bus.cab       = 8'h02;
        cycle();
        bus.cab = '0;
        cycle();
        check("s6_flip", 32'({bus.move_req, bus.direct}), 32'b11);
        bus.tick = 1'b1;
        wait_idle("s6_idle", 300);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            clear_buttons();
            bus.tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 11) == 0) bus.hall_up[$urandom_range(0, NF - 1)] = 1'b1;
            if ($urandom_range(0, 11) == 0) bus.hall_dn[$urandom_range(0, NF - 1)] = 1'b1;
            if ($urandom_range(0, 9) == 0)  bus.cab[$urandom_range(0, NF - 1)] = 1'b1;
            bus.door_open_btn  = ($urandom_range(0, 49) == 0);
            bus.door_close_btn = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
